// File: rtl/board_render_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | board_render_pkg: screen geometry, colours and cell encodings shared by    |
// | the board renderer and the screen flasher.                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package board_render_pkg;

    localparam int SCR_WIDTH        = 160;
    localparam int SCR_HEIGHT       = 120;
    localparam int COLOR_SIZE       = 3;
    localparam int MEMORY_SIZE_BITS = 15;

    typedef logic [MEMORY_SIZE_BITS-1:0] fb_addr_t;
    typedef logic [COLOR_SIZE-1:0]       color_t;

    localparam color_t SCREEN_BG  = 3'b000;
    localparam color_t BOARD_BG   = 3'b110;
    localparam color_t GRID_COLOR = 3'b000;
    localparam color_t P1_COLOR   = 3'b001;
    localparam color_t P2_COLOR   = 3'b111;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_P1    = 2'b01,
        CELL_P2    = 2'b10,
        CELL_RSVD  = 2'b11
    } cell_state_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAW  = 3'd4,
        ST_DONE  = 3'd5
    } render_state_e;

    function automatic fb_addr_t coor_to_offset(input fb_addr_t x, input fb_addr_t y);
        return fb_addr_t'(y * fb_addr_t'(SCR_WIDTH)) + x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_render_cell_pixel_color.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cell_pixel_color: colour of one pixel inside a board cell.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cell_pixel_color
    import board_render_pkg::*;
#(
    parameter int CELL_PX = 8,
    parameter int PX_W    = $clog2(CELL_PX)
) (
    input  logic [PX_W-1:0]       px_i,
    input  logic [PX_W-1:0]       py_i,
    input  logic [1:0]            stone_i,
    output logic [COLOR_SIZE-1:0] color_o
);

    logic w_inner;

    // Stones leave a one-pixel board-coloured margin inside the grid lines.
    assign w_inner = (px_i >= PX_W'(2)) && (px_i <= PX_W'(CELL_PX - 2)) &&
                     (py_i >= PX_W'(2)) && (py_i <= PX_W'(CELL_PX - 2));

    always_comb begin
        color_o = BOARD_BG;
        if ((px_i == '0) || (py_i == '0)) begin
            color_o = GRID_COLOR;
        end else if (w_inner && (stone_i == CELL_P1)) begin
            color_o = P1_COLOR;
        end else if (w_inner && (stone_i == CELL_P2)) begin
            color_o = P2_COLOR;
        end
    end

endmodule
`default_nettype wire

// File: rtl/board_render.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | board_render: clears the framebuffer, then draws the grid and stones of    |
// | the board cell by cell and hands the frame to the flasher.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module board_render
    import board_render_pkg::*;
#(
    parameter int BOARD_N  = 15,
    parameter int CELL_PX  = 8,
    parameter int BOARD_X0 = 20,
    parameter int BOARD_Y0 = 0
) (
    input  logic                        Clck,
    input  logic                        Reset,
    input  logic                        in_cont_signal,
    output logic                        out_cont_signal,
    input  logic                        next_fin_signal,
    output logic [7:0]                  board_addr,
    input  logic [1:0]                  board_data,
    output logic [MEMORY_SIZE_BITS-1:0] wr_addr,
    output logic [COLOR_SIZE-1:0]       wr_data,
    output logic                        wr_en
);

    localparam int PX_W = $clog2(CELL_PX);
    localparam int RC_W = $clog2(BOARD_N);

    localparam fb_addr_t          CLEAR_LAST = fb_addr_t'(SCR_WIDTH * SCR_HEIGHT - 1);
    localparam logic [PX_W-1:0]   PX_LAST    = PX_W'(CELL_PX - 1);
    localparam logic [RC_W-1:0]   RC_LAST    = RC_W'(BOARD_N - 1);

    if ((BOARD_X0 + BOARD_N * CELL_PX > SCR_WIDTH) ||
        (BOARD_Y0 + BOARD_N * CELL_PX > SCR_HEIGHT)) begin : g_bad_geometry
        $error("board_render: board does not fit on the screen");
    end
    if ((1 << PX_W) != CELL_PX) begin : g_bad_cell_px
        $error("board_render: CELL_PX must be a power of two");
    end
    if (BOARD_N * BOARD_N > 256) begin : g_bad_board_n
        $error("board_render: board does not fit the 8-bit board address");
    end

    render_state_e         state_q, state_d;
    logic [RC_W-1:0]       row_q, row_d, col_q, col_d;
    logic [PX_W-1:0]       px_q, px_d, py_q, py_d;
    logic [1:0]            stone_q, stone_d;
    logic                  out_cont_q, out_cont_d;
    logic                  wr_en_q, wr_en_d;
    fb_addr_t              wr_addr_q, wr_addr_d;
    color_t                wr_data_q, wr_data_d;
    logic [7:0]            board_addr_q, board_addr_d;

    logic [PX_W-1:0]       px_n, py_n;
    logic [1:0]            stone_n;
    logic [RC_W-1:0]       row_n, col_n;
    logic [7:0]            board_addr_n;
    fb_addr_t              w_pix_x, w_pix_y, w_pix_addr;
    color_t                w_pix_color;

    // Pixel about to be emitted: first pixel of a cell when leaving WAIT,
    // otherwise the successor of the current one (power-of-two wrap).
    always_comb begin
        px_n    = '0;
        py_n    = '0;
        stone_n = board_data;
        if (state_q == ST_DRAW) begin
            stone_n = stone_q;
            px_n    = px_q + 1'b1;
            py_n    = (px_q == PX_LAST) ? py_q + 1'b1 : py_q;
        end
    end

    assign col_n        = (col_q == RC_LAST) ? '0 : col_q + 1'b1;
    assign row_n        = (col_q == RC_LAST) ? row_q + 1'b1 : row_q;
    assign board_addr_n = 8'(row_n) * 8'(BOARD_N) + 8'(col_n);

    assign w_pix_x    = fb_addr_t'(BOARD_X0) + (fb_addr_t'(col_q) << PX_W) + fb_addr_t'(px_n);
    assign w_pix_y    = fb_addr_t'(BOARD_Y0) + (fb_addr_t'(row_q) << PX_W) + fb_addr_t'(py_n);
    assign w_pix_addr = coor_to_offset(w_pix_x, w_pix_y);

    cell_pixel_color #(
        .CELL_PX (CELL_PX),
        .PX_W    (PX_W)
    ) u_cell_pixel_color (
        .px_i    (px_n),
        .py_i    (py_n),
        .stone_i (stone_n),
        .color_o (w_pix_color)
    );

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        px_d         = px_q;
        py_d         = py_q;
        stone_d      = stone_q;
        out_cont_d   = out_cont_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        board_addr_d = board_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_cont_signal) begin
                    state_d   = ST_CLEAR;
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = SCREEN_BG;
                end
            end
            ST_CLEAR: begin
                if (wr_addr_q == CLEAR_LAST) begin
                    state_d      = ST_FETCH;
                    row_d        = '0;
                    col_d        = '0;
                    board_addr_d = '0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    wr_data_d = SCREEN_BG;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                state_d   = ST_DRAW;
                stone_d   = board_data;
                px_d      = px_n;
                py_d      = py_n;
                wr_en_d   = 1'b1;
                wr_addr_d = w_pix_addr;
                wr_data_d = w_pix_color;
            end
            ST_DRAW: begin
                if ((px_q == PX_LAST) && (py_q == PX_LAST)) begin
                    row_d        = row_n;
                    col_d        = col_n;
                    board_addr_d = board_addr_n;
                    if ((row_q == RC_LAST) && (col_q == RC_LAST)) begin
                        state_d    = ST_DONE;
                        out_cont_d = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    px_d      = px_n;
                    py_d      = py_n;
                    wr_en_d   = 1'b1;
                    wr_addr_d = w_pix_addr;
                    wr_data_d = w_pix_color;
                end
            end
            ST_DONE: begin
                if (next_fin_signal) begin
                    state_d    = ST_IDLE;
                    out_cont_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            px_q         <= '0;
            py_q         <= '0;
            stone_q      <= '0;
            out_cont_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            board_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            px_q         <= px_d;
            py_q         <= py_d;
            stone_q      <= stone_d;
            out_cont_q   <= out_cont_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            board_addr_q <= board_addr_d;
        end
    end

    assign out_cont_signal = out_cont_q;
    assign wr_en           = wr_en_q;
    assign wr_addr         = wr_addr_q;
    assign wr_data         = wr_data_q;
    assign board_addr      = board_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_board_render.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_board_render: self-checking bench for board_render.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_board_render;

    logic        Clck = 1'b0;
    logic        Reset = 1'b0;
    logic        in_cont_signal = 1'b0;
    logic        next_fin_signal = 1'b0;
    logic        out_cont_signal;
    logic [7:0]  board_addr;
    logic [1:0]  board_data;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;
    logic        wr_en;

    board_render dut (
        .Clck            (Clck),
        .Reset           (Reset),
        .in_cont_signal  (in_cont_signal),
        .out_cont_signal (out_cont_signal),
        .next_fin_signal (next_fin_signal),
        .board_addr      (board_addr),
        .board_data      (board_data),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_en           (wr_en)
    );

    always #5 Clck = ~Clck;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [1:0]  board_mem [0:255];
    logic [2:0]  fb        [0:19199];
    logic [17:0] cap_q[$];
    logic [17:0] exp_q[$];

    always @(posedge Clck) cyc <= cyc + 1;
    always @(posedge Clck) board_data <= board_mem[board_addr];

    always @(negedge Clck) begin
        if (wr_en === 1'b1) begin
            cap_q.push_back({wr_addr, wr_data});
            if (wr_addr < 15'd19200) fb[wr_addr] <= wr_data;
        end
    end

    typedef struct {
        int         row;
        int         col;
        int         st;
        int         addr;
        logic [2:0] exp;
    } probe_t;

    probe_t probes [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2:0] cell_rule(input int ox, input int oy, input int st);
        if (ox == 0 || oy == 0) return 3'b000;
        if (ox >= 2 && ox <= 6 && oy >= 2 && oy <= 6) begin
            if (st == 1) return 3'b001;
            if (st == 2) return 3'b111;
        end
        return 3'b110;
    endfunction

    // Final image by inverse mapping from a screen coordinate to its cell.
    function automatic logic [2:0] model_pixel(input int x, input int y);
        int bx;
        bx = x - 20;
        if (bx < 0 || bx >= 120 || y >= 120) return 3'b000;
        return cell_rule(bx % 8, y % 8, int'(board_mem[(y / 8) * 15 + bx / 8]));
    endfunction

    task automatic build_expected();
        int a;
        exp_q.delete();
        for (int i = 0; i < 19200; i++) exp_q.push_back({15'(i), 3'b000});
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++)
                for (int py = 0; py < 8; py++)
                    for (int px = 0; px < 8; px++) begin
                        a = (r * 8 + py) * 160 + 20 + c * 8 + px;
                        exp_q.push_back({15'(a), cell_rule(px, py, int'(board_mem[r * 15 + c]))});
                    end
    endtask

    task automatic check_stream(input string name);
        int first;
        int n;
        first = -1;
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (first < 0 && cap_q[i] !== exp_q[i]) first = i;
        n_checks++;
        if (first >= 0) begin
            n_fail++;
            $display("FAIL %s: write %0d got addr %0d data %0d, expected addr %0d data %0d",
                     name, first, cap_q[first][17:3], cap_q[first][2:0],
                     exp_q[first][17:3], exp_q[first][2:0]);
        end else if (cap_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s: got %0d writes, expected %0d", name, cap_q.size(), exp_q.size());
        end
    endtask

    task automatic check_image(input string name);
        int mism;
        mism = 0;
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                if (fb[y * 160 + x] !== model_pixel(x, y)) mism++;
        chk(name, 64'(mism), 64'd0);
    endtask

    task automatic clear_capture();
        cap_q.delete();
        for (int i = 0; i < 19200; i++) fb[i] = 3'b101;
    endtask

    task automatic random_board();
        for (int i = 0; i < 256; i++) board_mem[i] = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done(input string name, output int at_cyc);
        bit found;
        found = 1'b0;
        at_cyc = cyc;
        for (int i = 0; i < 40000 && !found; i++) begin
            @(negedge Clck);
            if (out_cont_signal === 1'b1) begin
                found = 1'b1;
                at_cyc = cyc;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: out_cont_signal never rose, got 0, expected 1", name);
        end
    endtask

    initial begin
        int a;
        int r;
        int bad;

        probes[0]  = '{0, 0, 0, 20, 3'b000};
        probes[1]  = '{0, 0, 0, 181, 3'b110};
        probes[2]  = '{7, 7, 1, 9519, 3'b001};
        probes[3]  = '{14, 14, 2, 18696, 3'b111};
        probes[4]  = '{0, 1, 3, 511, 3'b110};
        probes[5]  = '{0, 1, 3, 508, 3'b000};
        probes[6]  = '{7, 7, 1, 10002, 3'b001};
        probes[7]  = '{7, 7, 1, 10163, 3'b110};
        probes[8]  = '{7, 7, 1, 9517, 3'b110};
        probes[9]  = '{14, 14, 2, 18692, 3'b000};
        probes[10] = '{0, 0, 0, 0, 3'b000};
        probes[11] = '{14, 14, 2, 19199, 3'b000};
        probes[12] = '{14, 14, 2, 19179, 3'b110};
        probes[13] = '{14, 14, 2, 19180, 3'b000};

        for (int i = 0; i < 256; i++) board_mem[i] = 2'b00;
        clear_capture();

        Reset = 1'b0;
        repeat (3) @(negedge Clck);
        chk("reset_out_cont", 64'(out_cont_signal), 64'd0);
        chk("reset_wr_en", 64'(wr_en), 64'd0);
        chk("reset_wr_addr", 64'(wr_addr), 64'd0);
        chk("reset_wr_data", 64'(wr_data), 64'd0);
        chk("reset_board_addr", 64'(board_addr), 64'd0);
        Reset = 1'b1;
        repeat (3) @(negedge Clck);
        chk("idle_no_write", 64'(wr_en), 64'd0);

        // Frame 1: random board with fixed probe cells, single-cycle start pulse.
        random_board();
        for (int i = 0; i < 14; i++) board_mem[probes[i].row * 15 + probes[i].col] = 2'(probes[i].st);
        build_expected();
        clear_capture();
        in_cont_signal = 1'b1;
        @(negedge Clck);
        a = cyc;
        in_cont_signal = 1'b0;
        chk("f1_first_wr_en", 64'(wr_en), 64'd1);
        chk("f1_first_wr_addr", 64'(wr_addr), 64'd0);
        wait_done("f1_done", r);
        chk("f1_latency", 64'(r - a), 64'd34050);
        check_stream("f1_write_stream");
        check_image("f1_image");
        for (int i = 0; i < 14; i++)
            chk($sformatf("probe_%0d_addr_%0d", i, probes[i].addr),
                64'(fb[probes[i].addr]), 64'(probes[i].exp));

        // Hold DONE, then continuation with in_cont_signal already high.
        bad = 0;
        in_cont_signal = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clck);
            if (wr_en !== 1'b0 || out_cont_signal !== 1'b1) bad++;
        end
        chk("done_hold", 64'(bad), 64'd0);
        clear_capture();
        random_board();
        build_expected();
        next_fin_signal = 1'b1;
        @(negedge Clck);
        next_fin_signal = 1'b0;
        chk("release_out_cont", 64'(out_cont_signal), 64'd0);
        chk("release_wr_en", 64'(wr_en), 64'd0);
        @(negedge Clck);
        a = cyc;
        chk("f2_restart_wr_en", 64'(wr_en), 64'd1);
        chk("f2_restart_wr_addr", 64'(wr_addr), 64'd0);
        repeat (50) @(negedge Clck);
        in_cont_signal = 1'b0;
        wait_done("f2_done", r);
        chk("f2_latency", 64'(r - a), 64'd34050);
        check_stream("f2_write_stream");
        check_image("f2_image");

        // Frame 3: asynchronous reset in the middle of drawing.
        next_fin_signal = 1'b1;
        @(negedge Clck);
        next_fin_signal = 1'b0;
        chk("f3_idle_out_cont", 64'(out_cont_signal), 64'd0);
        in_cont_signal = 1'b1;
        @(negedge Clck);
        in_cont_signal = 1'b0;
        repeat (19300) @(negedge Clck);
        chk("f3_in_draw", 64'(wr_en), 64'd1);
        #2 Reset = 1'b0;
        #1;
        chk("async_rst_wr_en", 64'(wr_en), 64'd0);
        chk("async_rst_out_cont", 64'(out_cont_signal), 64'd0);
        chk("async_rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("async_rst_board_addr", 64'(board_addr), 64'd0);
        @(negedge Clck);
        Reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clck);
            if (wr_en !== 1'b0 || out_cont_signal !== 1'b0) bad++;
        end
        chk("post_rst_idle", 64'(bad), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
